// File: rtl/dt_tree_engine.sv
// Sequential binary decision-tree engine: walks one node per clock through a
// loadable node table and reports the class label reached for each sample.
module dt_tree_engine #(
    parameter int N_FEAT    = 51,
    parameter int N_NODES   = 64,
    parameter int CLASS_W   = 1,
    parameter int MAX_STEPS = 16,
    localparam int FIDX_W   = $clog2(N_FEAT),
    localparam int NIDX_W   = $clog2(N_NODES),
    localparam int NODE_W   = 1 + FIDX_W + 2 * NIDX_W,
    localparam int STEP_W   = $clog2(MAX_STEPS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [NIDX_W-1:0]  cfg_addr,
    input  logic [NODE_W-1:0]  cfg_wdata,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_FEAT-1:0]  in_feat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    output logic [STEP_W-1:0]  out_steps
);

    localparam int FPAD_W = 2 ** FIDX_W;
    localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [NODE_W-1:0]    node_q [N_NODES];
    logic [N_FEAT-1:0]    feat_q;
    logic [NIDX_W-1:0]    ptr_q;
    logic [STEP_W-1:0]    step_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [CLASS_W-1:0]   out_class_q;
    logic                 out_err_q;
    logic [STEP_W-1:0]    out_steps_q;
    logic                 cfg_err_q;

    logic [NODE_W-1:0]    node_s;
    logic                 is_leaf_s;
    logic [FIDX_W-1:0]    fidx_s;
    logic [NIDX_W-1:0]    hi_s;
    logic [NIDX_W-1:0]    lo_s;
    logic [FPAD_W-1:0]    feat_pad_s;
    logic                 feat_bit_s;
    logic [NIDX_W-1:0]    ptr_d;
    logic                 last_step_s;
    logic                 accept_s;
    logic                 cfg_ok_s;
    logic                 cfg_drop_s;

    // Current-node decode and next-pointer selection; out-of-range pointers and
    // feature indices fall back to leaf/class 0 and a zero feature bit.
    always_comb begin
        node_s = LEAF0;
        if (32'(ptr_q) < N_NODES) begin
            node_s = node_q[ptr_q];
        end else begin
            node_s = LEAF0;
        end
        is_leaf_s   = node_s[NODE_W-1];
        fidx_s      = node_s[NODE_W-2 -: FIDX_W];
        hi_s        = node_s[2*NIDX_W-1 -: NIDX_W];
        lo_s        = node_s[NIDX_W-1:0];
        feat_pad_s  = FPAD_W'(feat_q);
        feat_bit_s  = feat_pad_s[fidx_s];
        ptr_d       = feat_bit_s ? hi_s : lo_s;
        last_step_s = (step_q == STEP_W'(MAX_STEPS - 1));
    end

    // Handshake qualification and config-write accept/drop decisions.
    always_comb begin
        accept_s   = in_valid & in_ready_q;
        cfg_ok_s   = 1'b0;
        cfg_drop_s = 1'b0;
        if (cfg_we) begin
            cfg_ok_s   = (state_q == IDLE) & ~accept_s & (32'(cfg_addr) < N_NODES);
            cfg_drop_s = ~cfg_ok_s;
        end else begin
            cfg_ok_s   = 1'b0;
            cfg_drop_s = 1'b0;
        end
    end

    // Node table storage; reset makes every node a class-0 leaf.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                node_q[i] <= LEAF0;
            end
        end else if (cfg_ok_s) begin
            node_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Walk controller with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            feat_q      <= '0;
            ptr_q       <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_err_q   <= 1'b0;
            out_steps_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= cfg_drop_s;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        feat_q     <= in_feat;
                        ptr_q      <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= WALK;
                    end
                end
                WALK: begin
                    if (is_leaf_s) begin
                        out_class_q <= lo_s[CLASS_W-1:0];
                        out_err_q   <= 1'b0;
                        out_steps_q <= step_q + STEP_W'(1);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (last_step_s) begin
                        // Step budget exhausted on an internal node: cyclic or too-deep tree.
                        out_class_q <= '0;
                        out_err_q   <= 1'b1;
                        out_steps_q <= STEP_W'(MAX_STEPS);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        ptr_q  <= ptr_d;
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_err   = out_err_q;
    assign out_steps = out_steps_q;
    assign cfg_err   = cfg_err_q;

endmodule
